// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester, TX-shifter and status signals of the UART TX scheduler
interface uart_tx_scheduler_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0] ack;
  logic [3:0] bicS;
  logic clr_err;
  logic [7:0] dataOut;
  logic load;
  logic transmit;
  logic busy;
  logic timeout_err;
  modport master (output req, req_data, bicS, clr_err,
                  input ack, dataOut, load, transmit, busy, timeout_err);
  modport slave (input req, req_data, bicS, clr_err,
                 output ack, dataOut, load, transmit, busy, timeout_err);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter among NREQ byte producers.
// Define UART_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module uart_tx_scheduler #(
  parameter int NREQ = 4,
  parameter logic [3:0] BIC_LAST = 4'd10,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clock,
  input logic reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, SEND, GAP} state_t;
  state_t state, state_d;
  logic [7:0] data_q, data_d;
  logic load_q, load_d, tx_q, tx_d, busy_q, busy_d, err_q, err_d, err_set, found;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [WW-1:0] wd, wd_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [PW-1:0] g;
  logic [PW:0] cand;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
  logic [PW-1:0] rr_ptr, rr_d;
`endif
  always_comb begin
    found = 1'b0;
    g = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
      cand = (PW+1)'(i);
`else
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      cand = cand >= (PW+1)'(NREQ) ? cand - (PW+1)'(NREQ) : cand;
`endif
      if (!found && bus.req[cand[PW-1:0]]) begin
        found = 1'b1;
        g = cand[PW-1:0];
      end
    end
  end
  always_comb begin
    state_d = state;
    data_d = data_q;
    load_d = load_q;
    tx_d = tx_q;
    busy_d = busy_q;
    ack_d = '0;
    wd_d = wd;
    gap_d = gap_cnt;
    err_set = 1'b0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
    rr_d = rr_ptr;
`endif
    case (state)
      IDLE: if (found) begin
        state_d = LOAD;
        data_d = bus.req_data[{g, 3'b000} +: 8];
        ack_d[g] = 1'b1;
        load_d = 1'b0;
        busy_d = 1'b1;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
        rr_d = g == PW'(NREQ-1) ? '0 : g + 1'b1;
`endif
      end
      LOAD: begin
        state_d = ARM;
        load_d = 1'b1;
      end
      ARM: begin
        state_d = SEND;
        tx_d = 1'b1;
        wd_d = '0;
      end
      SEND: if (bus.bicS == BIC_LAST || wd == WW'(TIMEOUT_CYC-1)) begin
        // completion is checked first so a simultaneous timeout is not flagged
        err_set = bus.bicS != BIC_LAST;
        tx_d = 1'b0;
        state_d = GAP;
        gap_d = GW'(GAP_CYCLES);
      end else begin
        wd_d = wd + 1'b1;
      end
      GAP: begin
        gap_d = gap_cnt - 1'b1;
        state_d = gap_cnt == GW'(1) ? IDLE : GAP;
        busy_d = gap_cnt != GW'(1);
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set | (err_q & ~bus.clr_err);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      data_q <= 8'h2D;
      load_q <= 1'b1;
      tx_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= '0;
      wd <= '0;
      gap_cnt <= '0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      state <= state_d;
      data_q <= data_d;
      load_q <= load_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      err_q <= err_d;
      ack_q <= ack_d;
      wd <= wd_d;
      gap_cnt <= gap_d;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      rr_ptr <= rr_d;
`endif
    end
  end
  assign bus.dataOut = data_q;
  assign bus.load = load_q;
  assign bus.transmit = tx_q;
  assign bus.busy = busy_q;
  assign bus.timeout_err = err_q;
  assign bus.ack = ack_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed vector bench for uart_tx_scheduler (NREQ=4, defaults).
module tb_uart_tx_scheduler;
  localparam logic [3:0] BL = 4'd10;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  uart_tx_scheduler_if #(.NREQ(4)) bus();
  uart_tx_scheduler dut (.clock(clock), .reset(reset), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [3:0] req;
    int g_rr;
    int g_fx;
    int send_len;
  } vec_t;
  vec_t vt[10];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic finish_byte(input string tag, input int exp_lat, input int len);
    int n;
    n = 0;
    while (!bus.transmit && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_tx_lat"}, n, exp_lat);
    repeat (len) tick();
    chk({tag, "_tx_hold"}, bus.transmit, 1);
    bus.bicS = BL;
    tick();
    bus.bicS = 4'd0;
    chk({tag, "_tx_fall"}, bus.transmit, 0);
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_gap_len"}, n, 4);
  endtask
  task automatic run_long(input string tag, input bit hit_last);
    int n;
    bus.req = 4'b0001;
    tick();
    chk({tag, "_ack"}, bus.ack, 4'b0001);
    bus.req = 4'b0000;
    n = 0;
    while (!bus.transmit && n < 8) begin
      tick();
      n++;
    end
    n = 0;
    while (bus.transmit && n < 5000) begin
      n++;
      if (n == 4096) begin
        if (hit_last) bus.bicS = BL;
        else bus.clr_err = 1'b1;
      end
      tick();
    end
    bus.bicS = 4'd0;
    bus.clr_err = 1'b0;
    chk({tag, "_send_len"}, n, 4096);
    chk({tag, "_err"}, bus.timeout_err, hit_last ? 0 : 1);
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, bus.busy, 0);
  endtask
  initial begin
    bit seen;
    int ge;
    bus.req = '0;
    bus.req_data = {8'h64, 8'h63, 8'h62, 8'h61};
    bus.bicS = 4'd0;
    bus.clr_err = 1'b0;
    vt[0] = '{4'b1111, 0, 0, 3};
    vt[1] = '{4'b1111, 1, 0, 1};
    vt[2] = '{4'b1111, 2, 0, 5};
    vt[3] = '{4'b1111, 3, 0, 2};
    vt[4] = '{4'b1111, 0, 0, 0};
    vt[5] = '{4'b1010, 1, 1, 4};
    vt[6] = '{4'b1010, 3, 1, 2};
    vt[7] = '{4'b1010, 1, 1, 1};
    vt[8] = '{4'b0100, 2, 2, 3};
    vt[9] = '{4'b1001, 3, 0, 2};
    #2 reset = 1'b0;
    #1;
    chk("rst_ack", bus.ack, 0);
    chk("rst_load", bus.load, 1);
    chk("rst_tx", bus.transmit, 0);
    chk("rst_data", bus.dataOut, 8'h2D);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.timeout_err, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    tick();
    bus.req_data[7:0] = 8'h67;
    bus.req = 4'b0001;
    tick();
    chk("t1_ack", bus.ack, 4'b0001);
    chk("t1_data", bus.dataOut, 8'h67);
    chk("t1_load_low", bus.load, 0);
    chk("t1_busy", bus.busy, 1);
    bus.req = 4'b0000;
    tick();
    chk("t1_load_high", bus.load, 1);
    chk("t1_ack_clr", bus.ack, 0);
    chk("t1_tx_arm", bus.transmit, 0);
    tick();
    chk("t1_tx_rise", bus.transmit, 1);
    repeat (4) tick();
    chk("t1_tx_hold", bus.transmit, 1);
    bus.bicS = BL;
    tick();
    bus.bicS = 4'd0;
    chk("t1_tx_fall", bus.transmit, 0);
    chk("t1_busy_gap", bus.busy, 1);
    repeat (3) tick();
    chk("t1_gap3", bus.busy, 1);
    tick();
    chk("t1_idle", bus.busy, 0);
    chk("t1_err", bus.timeout_err, 0);
    bus.req_data[7:0] = 8'h61;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.req = vt[i].req;
      tick();
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
      ge = vt[i].g_fx;
`else
      ge = vt[i].g_rr;
`endif
      chk($sformatf("v%0d_ack", i), bus.ack, 32'(1 << ge));
      chk($sformatf("v%0d_data", i), bus.dataOut, 32'(8'h61 + ge));
      finish_byte($sformatf("v%0d", i), 2, vt[i].send_len);
      bus.req = 4'b0000;
    end
    bus.req = 4'b0001;
    tick();
    chk("t6_ack", bus.ack, 4'b0001);
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    finish_byte("t6", 1, 2);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= (bus.ack != 0) | bus.busy | bus.transmit;
    end
    chk("t6_no_grant", seen, 0);
    run_long("t3", 1'b0);
    repeat (3) tick();
    chk("t3_err_sticky", bus.timeout_err, 1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t3_err_clr", bus.timeout_err, 0);
    run_long("t3b", 1'b1);
    bus.req = 4'b0100;
    tick();
    chk("t4_ack", bus.ack, 4'b0100);
    bus.req = 4'b0000;
    repeat (5) tick();
    chk("t4_tx", bus.transmit, 1);
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_tx", bus.transmit, 0);
    chk("t4_rst_load", bus.load, 1);
    chk("t4_rst_data", bus.dataOut, 8'h2D);
    chk("t4_rst_busy", bus.busy, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk("t4_regrant", bus.ack, 4'b0001);
    chk("t4_data", bus.dataOut, 8'h61);
    bus.req = 4'b0000;
    finish_byte("t4", 2, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
